pipeline_hazard_unit: RTL and testbench

- Control-side counterpart of the IF_ID/ID_EX/EX_MEM/MEM_WB pipeline registers. Those registers only capture data; this block drives them.
- Reads the register-address and control fields back out of the pipeline registers. From them it produces:
  - forwarding selects for the EX-stage ALU operand muxes;
  - load-use stall controls;
  - taken-branch/jump flush controls.
- Sits beside the datapath in the processor top. A small FSM guarantees single-cycle stall and flush sequencing, and saturating counters record hazard statistics.

---
 rtl/pipeline_hazard_unit_if.sv | 51 +++++
 rtl/pipeline_hazard_unit.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// Bus between the pipeline registers and the hazard unit:
// field readback in, forwarding/stall/flush controls out.
interface pipeline_hazard_unit_if #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_branch;
  logic              mem_zero;
  logic              mem_jump;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic              pc_redirect;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_memread,
    output mem_rd, mem_regwrite, mem_branch,
    output mem_zero, mem_jump, wb_rd, wb_regwrite,
    input  forward_a, forward_b, pc_write,
    input  ifid_write, idex_bubble, flush_ifid,
    input  flush_idex, flush_exmem, pc_redirect,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_memread,
    input  mem_rd, mem_regwrite, mem_branch,
    input  mem_zero, mem_jump, wb_rd, wb_regwrite,
    output forward_a, forward_b, pc_write,
    output ifid_write, idex_bubble, flush_ifid,
    output flush_idex, flush_exmem, pc_redirect,
    output state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard control for the 5-stage pipeline: operand forwarding,
// load-use stall, redirect flush, and saturating hazard stats.
module pipeline_hazard_unit #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic redirect;
  logic load_use;
  logic stall_inc;
  logic flush_inc;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && m_rd != '0 && m_rd == src)
      sel = 2'b10;
    else if (w_we && w_rd != '0 && w_rd == src)
      sel = 2'b01;
    return sel;
  endfunction

  assign redirect = hz.mem_jump
                  | (hz.mem_branch & hz.mem_zero);

  assign load_use = hz.ex_memread
                  && hz.ex_rt != '0
                  && (hz.ex_rt == hz.id_rs
                   || hz.ex_rt == hz.id_rt)
                  && state_q != STALL;

  always_comb begin
    hz.forward_a   = 2'b00;
    hz.forward_b   = 2'b00;
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_bubble = 1'b0;
    hz.flush_ifid  = 1'b0;
    hz.flush_idex  = 1'b0;
    hz.flush_exmem = 1'b0;
    hz.pc_redirect = 1'b0;
    state_d        = RUN;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (!rst) begin
      hz.forward_a = fwd_sel(hz.ex_rs,
        hz.mem_rd, hz.mem_regwrite,
        hz.wb_rd, hz.wb_regwrite);
      hz.forward_b = fwd_sel(hz.ex_rt,
        hz.mem_rd, hz.mem_regwrite,
        hz.wb_rd, hz.wb_regwrite);
      // load_use already carries the STALL mask,
      // so every state resolves the same way
      if (redirect) begin
        hz.pc_redirect = 1'b1;
        hz.flush_ifid  = 1'b1;
        hz.flush_idex  = 1'b1;
        hz.flush_exmem = 1'b1;
        state_d        = FLUSH;
        flush_inc      = 1'b1;
      end else if (load_use) begin
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_bubble = 1'b1;
        state_d        = STALL;
        stall_inc      = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.state     = state_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed checks for pipeline_hazard_unit, plus a
// narrow-counter instance for saturation.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.CNT_W(16), .REG_AW(5)) hzi ();
  pipeline_hazard_unit_if #(.CNT_W(2),  .REG_AW(5)) smi ();

  pipeline_hazard_unit #(.CNT_W(16), .REG_AW(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hzi.slave)
  );

  pipeline_hazard_unit #(.CNT_W(2), .REG_AW(5)) u_small (
    .clk (clk),
    .rst (rst),
    .hz  (smi.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    hzi.id_rs = '0; hzi.id_rt = '0;
    hzi.ex_rs = '0; hzi.ex_rt = '0;
    hzi.ex_memread = 0;
    hzi.mem_rd = '0; hzi.mem_regwrite = 0;
    hzi.mem_branch = 0; hzi.mem_zero = 0;
    hzi.mem_jump = 0;
    hzi.wb_rd = '0; hzi.wb_regwrite = 0;
  endtask

  task automatic clr_small();
    smi.id_rs = '0; smi.id_rt = '0;
    smi.ex_rs = '0; smi.ex_rt = '0;
    smi.ex_memread = 0;
    smi.mem_rd = '0; smi.mem_regwrite = 0;
    smi.mem_branch = 0; smi.mem_zero = 0;
    smi.mem_jump = 0;
    smi.wb_rd = '0; smi.wb_regwrite = 0;
  endtask

  task automatic set_load_use();
    hzi.ex_memread = 1;
    hzi.ex_rt = 5'd9;
    hzi.id_rt = 5'd9;
    hzi.id_rs = 5'd1;
  endtask

  initial begin
    clr();
    clr_small();
    // reset held with hazard-looking inputs
    hzi.mem_regwrite = 1; hzi.mem_rd = 5'd8;
    hzi.ex_rs = 5'd8; hzi.mem_jump = 1;
    repeat (2) @(negedge clk);
    check("rst_fwd_a", hzi.forward_a, 2'b00);
    check("rst_pc_write", hzi.pc_write, 1);
    check("rst_ifid_write", hzi.ifid_write, 1);
    check("rst_redirect", hzi.pc_redirect, 0);
    check("rst_flush_ifid", hzi.flush_ifid, 0);
    check("rst_state", hzi.state, 2'b00);
    check("rst_stall_cnt", hzi.stall_cnt, 0);
    check("rst_flush_cnt", hzi.flush_cnt, 0);
    rst = 0;
    clr();

    // forwarding
    hzi.mem_regwrite = 1; hzi.mem_rd = 5'd8;
    hzi.wb_regwrite = 1; hzi.wb_rd = 5'd8;
    hzi.ex_rs = 5'd8; hzi.ex_rt = 5'd3;
    #1;
    check("exmem_fwd_a", hzi.forward_a, 2'b10);
    check("exmem_fwd_b", hzi.forward_b, 2'b00);
    hzi.ex_rt = 5'd8;
    #1;
    check("both_match_b", hzi.forward_b, 2'b10);
    hzi.mem_regwrite = 0;
    #1;
    check("memwb_fwd_a", hzi.forward_a, 2'b01);
    check("memwb_fwd_b", hzi.forward_b, 2'b01);
    hzi.mem_regwrite = 1; hzi.mem_rd = 5'd4;
    hzi.ex_rs = 5'd4;
    #1;
    check("split_fwd_a", hzi.forward_a, 2'b10);
    check("split_fwd_b", hzi.forward_b, 2'b01);
    clr();
    hzi.mem_regwrite = 1; hzi.mem_rd = 5'd0;
    hzi.wb_regwrite = 1; hzi.wb_rd = 5'd0;
    #1;
    check("r0_fwd_a", hzi.forward_a, 2'b00);
    check("r0_fwd_b", hzi.forward_b, 2'b00);
    clr();
    hzi.mem_branch = 1;
    #1;
    check("nt_branch_redirect", hzi.pc_redirect, 0);
    clr();

    // load-use stall
    @(negedge clk);
    set_load_use();
    #1;
    check("lu_pc_write", hzi.pc_write, 0);
    check("lu_ifid_write", hzi.ifid_write, 0);
    check("lu_bubble", hzi.idex_bubble, 1);
    check("lu_state_run", hzi.state, 2'b00);
    @(negedge clk);
    check("stall_state", hzi.state, 2'b01);
    check("stall_pc_write", hzi.pc_write, 1);
    check("stall_ifid_write", hzi.ifid_write, 1);
    check("stall_bubble", hzi.idex_bubble, 0);
    check("stall_cnt_1", hzi.stall_cnt, 1);
    @(negedge clk);
    check("post_stall_state", hzi.state, 2'b00);
    clr();
    @(negedge clk);
    check("stall_cnt_hold", hzi.stall_cnt, 1);
    check("back_to_run", hzi.state, 2'b00);

    // branch beats stall
    set_load_use();
    hzi.mem_branch = 1; hzi.mem_zero = 1;
    #1;
    check("br_redirect", hzi.pc_redirect, 1);
    check("br_flush_ifid", hzi.flush_ifid, 1);
    check("br_flush_idex", hzi.flush_idex, 1);
    check("br_flush_exmem", hzi.flush_exmem, 1);
    check("br_pc_write", hzi.pc_write, 1);
    check("br_bubble", hzi.idex_bubble, 0);
    @(negedge clk);
    check("br_state", hzi.state, 2'b10);
    check("br_flush_cnt", hzi.flush_cnt, 1);
    check("br_stall_cnt", hzi.stall_cnt, 1);
    clr();
    #1;
    check("flush_state_quiet", hzi.flush_ifid, 0);
    @(negedge clk);
    check("flush_to_run", hzi.state, 2'b00);

    // redirect while in STALL
    set_load_use();
    @(negedge clk);
    check("s2_state", hzi.state, 2'b01);
    check("s2_stall_cnt", hzi.stall_cnt, 2);
    clr();
    hzi.mem_jump = 1;
    #1;
    check("s2_redirect", hzi.pc_redirect, 1);
    check("s2_flush_idex", hzi.flush_idex, 1);
    @(negedge clk);
    check("s2_to_flush", hzi.state, 2'b10);
    check("s2_flush_cnt", hzi.flush_cnt, 2);
    clr();
    @(negedge clk);
    check("s2_run", hzi.state, 2'b00);

    // back-to-back jumps
    hzi.mem_jump = 1;
    #1;
    check("j1_flush_ifid", hzi.flush_ifid, 1);
    @(negedge clk);
    check("j1_state", hzi.state, 2'b10);
    check("j1_flush_cnt", hzi.flush_cnt, 3);
    check("j2_flush_exmem", hzi.flush_exmem, 1);
    @(negedge clk);
    check("j2_state", hzi.state, 2'b10);
    check("j2_flush_cnt", hzi.flush_cnt, 4);
    clr();
    @(negedge clk);
    check("j_run", hzi.state, 2'b00);

    // saturation on the 2-bit instance
    smi.mem_jump = 1;
    repeat (3) @(negedge clk);
    check("sat_at_3", smi.flush_cnt, 3);
    repeat (2) @(negedge clk);
    check("sat_hold", smi.flush_cnt, 3);
    check("sat_state", smi.state, 2'b10);
    smi.mem_jump = 0;

    // reset mid-stall
    set_load_use();
    @(negedge clk);
    check("rs_state", hzi.state, 2'b01);
    check("rs_stall_cnt", hzi.stall_cnt, 3);
    rst = 1;
    hzi.mem_jump = 1; hzi.mem_regwrite = 1;
    hzi.mem_rd = 5'd8; hzi.ex_rs = 5'd8;
    #1;
    check("rs_fwd_a", hzi.forward_a, 2'b00);
    check("rs_redirect", hzi.pc_redirect, 0);
    check("rs_flush_ifid", hzi.flush_ifid, 0);
    check("rs_bubble", hzi.idex_bubble, 0);
    check("rs_pc_write", hzi.pc_write, 1);
    @(negedge clk);
    check("rs_state_run", hzi.state, 2'b00);
    check("rs_stall_clr", hzi.stall_cnt, 0);
    check("rs_flush_clr", hzi.flush_cnt, 0);
    check("rs_small_clr", smi.flush_cnt, 0);
    rst = 0;
    clr();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
